// File: rtl/one_to_many_demux_pkg.sv
// Shared definitions for the hub-side message fan-out path.
// Holds the destination-field extractor, the drop counter width and the
// default broadcast flag position (measured down from the message MSB).
package helios_hub_pkg;

  localparam int unsigned DROP_CNT_WIDTH   = 16;
  localparam int unsigned BCAST_MSB_OFFSET = 1;
  localparam int unsigned DEST_MAX_W       = 32;
  localparam int unsigned MSG_MAX_W        = 1024;

  // Pull the destination field msg[lsb +: width] out of a zero-extended message.
  function automatic logic [DEST_MAX_W-1:0] extract_dest(
    input logic [MSG_MAX_W-1:0] msg,
    input int unsigned          lsb,
    input int unsigned          width
  );
    logic [DEST_MAX_W-1:0] d;
    d = '0;
    for (int unsigned b = 0; b < DEST_MAX_W; b++) begin
      if (b < width && (lsb + b) < MSG_MAX_W) d[b] = msg[lsb + b];
    end
    return d;
  endfunction

endpackage

// File: rtl/one_to_many_demux_buffer.sv
// demux_out_buffer: 2-entry registered FIFO for one output channel.
// Head data and valid come straight from flops; there is no bypass, so a
// push into an empty buffer shows up on the head one cycle later.
module demux_out_buffer #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              ready,
  output logic              valid,
  output logic              full,
  output logic [DATA_W-1:0] head
);

  logic [1:0]        occ_p1;
  logic [DATA_W-1:0] slot0_p1;
  logic [DATA_W-1:0] slot1_p1;
  logic              push_ok;
  logic              pop;

  assign valid   = (occ_p1 != 2'd0);
  assign full    = (occ_p1 == 2'd2);
  assign head    = slot0_p1;
  assign pop     = valid && ready;
  // A full buffer ignores pushes; the freed slot only counts from next cycle.
  assign push_ok = push && !full;

  // Storage update: slot0 is always the head, slot1 the second entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ_p1   <= 2'd0;
      slot0_p1 <= '0;
      slot1_p1 <= '0;
    end else begin
      unique case ({push_ok, pop})
        2'b10: begin
          if (occ_p1 == 2'd0) slot0_p1 <= push_data;
          else                slot1_p1 <= push_data;
          occ_p1 <= occ_p1 + 2'd1;
        end
        2'b01: begin
          slot0_p1 <= slot1_p1;
          occ_p1   <= occ_p1 - 2'd1;
        end
        2'b11: begin
          // Only reachable with one entry: the new message becomes head.
          slot0_p1 <= push_data;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/one_to_many_demux.sv
// one_to_many_demux: fans one ready/valid message stream out to
// TRUE_FIFO_COUNT per-destination channels, each behind its own 2-entry
// buffer. Out-of-range destinations are consumed and counted in drop_count.
// Optional feature macro: DEMUX_BROADCAST_EN -- when defined, a message with
// in_data[BCAST_BIT]=1 is pushed to every channel at once.
module one_to_many_demux
  import helios_hub_pkg::*;
#(
  parameter int unsigned HUB_FIFO_WIDTH  = 32,
  parameter int unsigned TRUE_FIFO_COUNT = 3,
  parameter int unsigned DEST_LSB        = 0,
  parameter int unsigned BCAST_BIT       = HUB_FIFO_WIDTH - BCAST_MSB_OFFSET
) (
  input  logic                                      clk,
  input  logic                                      reset_n,
  input  logic [HUB_FIFO_WIDTH-1:0]                 in_data,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  output logic [TRUE_FIFO_COUNT*HUB_FIFO_WIDTH-1:0] combined_fifo_in_data_vector,
  output logic [TRUE_FIFO_COUNT-1:0]                combined_fifo_in_valid_vector,
  input  logic [TRUE_FIFO_COUNT-1:0]                combined_fifo_in_ready_vector,
  output logic [DROP_CNT_WIDTH-1:0]                 drop_count
);

  localparam int unsigned DEST_WIDTH = $clog2(TRUE_FIFO_COUNT);

  logic [DEST_MAX_W-1:0]      dest;
  logic                       dest_ok;
  logic                       bcast;
  logic                       accept;
  logic                       drop;
  logic [TRUE_FIFO_COUNT-1:0] full;
  logic [TRUE_FIFO_COUNT-1:0] push;
  logic [DROP_CNT_WIDTH-1:0]  drop_cnt_p1;

  function automatic logic [DROP_CNT_WIDTH-1:0] sat_inc(
    input logic [DROP_CNT_WIDTH-1:0] cnt,
    input logic                      en
  );
    if (en && cnt != {DROP_CNT_WIDTH{1'b1}}) return cnt + 1'b1;
    return cnt;
  endfunction

  // Route decode: in_ready depends on in_data and buffer state only.
  always_comb begin
    dest    = extract_dest(MSG_MAX_W'(in_data), DEST_LSB, DEST_WIDTH);
    dest_ok = (dest < DEST_MAX_W'(TRUE_FIFO_COUNT));
    bcast   = 1'b0;
`ifdef DEMUX_BROADCAST_EN
    bcast   = in_data[BCAST_BIT];
`endif
    in_ready = 1'b1;
    if (bcast) begin
      in_ready = &(~full);
    end else begin
      for (int i = 0; i < int'(TRUE_FIFO_COUNT); i++) begin
        if (dest_ok && dest == DEST_MAX_W'(i)) in_ready = !full[i];
      end
    end
    accept = in_valid && in_ready;
    push   = '0;
    for (int i = 0; i < int'(TRUE_FIFO_COUNT); i++) begin
      push[i] = accept && (bcast || (dest_ok && dest == DEST_MAX_W'(i)));
    end
    drop = accept && !bcast && !dest_ok;
  end

  // Saturating count of discarded out-of-range messages.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) drop_cnt_p1 <= '0;
    else          drop_cnt_p1 <= sat_inc(drop_cnt_p1, drop);
  end

  assign drop_count = drop_cnt_p1;

  for (genvar g = 0; g < int'(TRUE_FIFO_COUNT); g++) begin : g_chan
    demux_out_buffer #(
      .DATA_W (HUB_FIFO_WIDTH)
    ) u_buf (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push[g]),
      .push_data (in_data),
      .ready     (combined_fifo_in_ready_vector[g]),
      .valid     (combined_fifo_in_valid_vector[g]),
      .full      (full[g]),
      .head      (combined_fifo_in_data_vector[g*HUB_FIFO_WIDTH +: HUB_FIFO_WIDTH])
    );
  end

endmodule
